instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute control unit for the down-sampling processor.
//  Drives the program counter's PC_control and latches the IRAM output into the IR.
//  Issues ALU, register-file and data-memory strobes.
//  Resolves conditional jumps itself, so PC_control=10 is issued only for taken jumps.
//  Sits between PC/IRAM and the datapath (ALU, register file, DRAM port).
// PARAMETERS
//  OPC_W     4   opcode width; opcode = instruction[15:12]
//  COND_W    4   jump-condition/func field width; field = instruction[11:8]
//  MEM_TMO   255 data-memory wait cycles before the fault trap; 0 disables the timeout
// PORTS
//  clock        in   1   rising-edge clock
//  reset_n      in   1   synchronous, active-low reset
//  start        in   1   1-cycle pulse; begins execution from the current PC
//  instruction  in   16  IRAM read data, valid 1 cycle after iram_en
//  Z_out        in   1   ALU zero flag, registered by the datapath
//  mem_ack      in   1   data-memory completion, 1-cycle pulse
//  PC_control   out  2   00 hold, 01 increment, 10 load jump address
//  iram_en      out  1   IRAM read strobe
//  ir_load      out  1   IR capture strobe
//  alu_en       out  1   ALU execute strobe
//  alu_op       out  4   ALU function = instruction[11:8] for ALU opcodes
//  reg_we       out  1   register-file write strobe
//  imm_sel      out  1   1: register write data = instruction[7:0]
//  mem_req      out  1   data-memory request, held until mem_ack
//  mem_we       out  1   1 store / 0 load; stable while mem_req=1
//  busy         out  1   1 in every state except IDLE and HALT
//  done         out  1   1-cycle pulse on END
//  fault        out  1   sticky flag; set on illegal opcode or memory timeout
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge)
//  - Abandons any operation, including a pending memory request; no ack is awaited.
//  - State becomes IDLE; every output is 0 (PC_control=00, fault=0).
//  Opcodes
//  - 0 NOP, 1 JMP, 2 LOAD, 3 STORE, 4 ALU, 5 LDI, F END; all other values are illegal.
//  FSM and outputs asserted in each state
//  - IDLE:   PC_control=00. start=1 -> FETCH.
//  - FETCH:  iram_en=1 -> FWAIT.
//  - FWAIT:  ir_load=1 -> DECODE.
//  - DECODE: all strobes 0; branches on the IR opcode.
//    NOP -> PCINC. JMP -> JUMP. LOAD/STORE -> MEMREQ. ALU -> EXEC. LDI -> WBACK.
//    END -> HALT with done=1 for one cycle. Illegal -> HALT with fault=1.
//  - EXEC:   alu_en=1 for 1 cycle -> PCINC.
//  - WBACK:  reg_we=1, imm_sel=1 for 1 cycle -> PCINC.
//  - MEMREQ: mem_req=1 and mem_we=(opcode==3) held until mem_ack.
//    mem_ack received the same cycle mem_req first rises is valid.
//    On ack: LOAD -> WBACK with imm_sel=0; STORE -> PCINC.
//    After MEM_TMO cycles without ack: fault=1 -> HALT.
//  - JUMP:   cond 0 is always taken, 1 is taken when Z_out=0, 2 is taken when Z_out=1.
//    Taken: PC_control=10. Not taken, or any other cond value: PC_control=01. Then -> FETCH.
//  - PCINC:  PC_control=01 for exactly 1 cycle -> FETCH.
//  - HALT:   all strobes 0; only reset_n leaves HALT. start is ignored here and in every busy state.
//  PC_control invariants
//  - Non-zero for exactly one cycle per instruction, and 00 in every other state.
//  - An 8-bit PC wraps 0xFF->0x00 naturally; the sequencer does no range check.
//  Cycle counts
//  - NOP, JMP: 4. ALU, LDI: 5. STORE: 4+N. LOAD: 5+N, where N = cycles from mem_req rise to mem_ack.
//  - Z_out is sampled in the JUMP state only; the datapath must settle Z by the cycle after EXEC.
// STRUCTURE
//  - Shared package proc_defs_pkg: opcode localparams, PC_control codes (PC_HOLD/PC_INC/PC_JMP),
//    jump-condition codes and the state encoding.
//  - Sub-module jump_cond_eval: combinational (cond, Z_out) -> taken. The PC reuses its encoding.
//  - Everything else is a single registered-state FSM with registered Moore outputs.
// TESTING
//  - Reset/idle: reset_n=0 for 2 cycles with start=1 -> all outputs 0, busy=0; no PC_control pulse.
//  - NOP then END at 0x00/0x01: start -> PC_control=01 once at cycle 4; done pulses; busy=0 after.
//  - JMP cond=2 to 0x40: Z_out=1 -> PC_control=10 exactly once.
//    Z_out=0 -> 01 and next fetch at the PC+1 address.
//  - LOAD with mem_ack delayed 3 cycles: mem_req high for 3 cycles and mem_we=0.
//    Then reg_we=1 with imm_sel=0, then PC_control=01.
//  - Faults: opcode 0x9 -> fault=1 and HALT. Separately, with MEM_TMO=4 and no mem_ack:
//    fault=1 after 4 cycles; a later start is ignored.
//  - Reset mid-STORE while mem_req=1 -> next cycle mem_req=0, state IDLE, fault cleared.

Source files
------------

// File: rtl/proc_defs_pkg.sv
// proc_defs_pkg: shared definitions for the down-sampling processor control path
//   opcodes        OP_*      instruction[15:12]
//   PC controls    PC_*      PC_control encoding (hold / increment / load jump address)
//   jump conds     JC_*      instruction[11:8] of a JMP
//   state_e                  sequencer state encoding
package proc_defs_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_JMP   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_ALU   = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h5;
    localparam logic [3:0] OP_END   = 4'hF;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;

    localparam logic [3:0] JC_ALWAYS = 4'h0;
    localparam logic [3:0] JC_NZ     = 4'h1;
    localparam logic [3:0] JC_Z      = 4'h2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_EXEC,
        S_WBACK,
        S_MEMREQ,
        S_JUMP,
        S_PCINC,
        S_HALT
    } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: control/status bundle between the sequencer and PC/IRAM/datapath
//   inputs to sequencer : start, instruction[15:0], Z_out, mem_ack
//   outputs             : PC_control[1:0], iram_en, ir_load, alu_en, alu_op[3:0],
//                         reg_we, imm_sel, mem_req, mem_we, busy, done, fault
//   master = sequencer side, slave = datapath side
interface instr_sequencer_if;

    logic        start;
    logic [15:0] instruction;
    logic        Z_out;
    logic        mem_ack;
    logic [1:0]  PC_control;
    logic        iram_en;
    logic        ir_load;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        imm_sel;
    logic        mem_req;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        input  start, instruction, Z_out, mem_ack,
        output PC_control, iram_en, ir_load, alu_en, alu_op, reg_we, imm_sel,
               mem_req, mem_we, busy, done, fault
    );

    modport slave (
        output start, instruction, Z_out, mem_ack,
        input  PC_control, iram_en, ir_load, alu_en, alu_op, reg_we, imm_sel,
               mem_req, mem_we, busy, done, fault
    );

endinterface

// File: rtl/jump_cond_eval.sv
// jump_cond_eval: combinational jump-condition resolver
//   cond_i  [COND_W-1:0]  condition field of the JMP instruction
//   z_i                   ALU zero flag
//   taken_o               1 when the jump is taken (unknown conditions are never taken)
module jump_cond_eval
    import proc_defs_pkg::*;
#(
    parameter int COND_W = 4
) (
    input  logic [COND_W-1:0] cond_i,
    input  logic              z_i,
    output logic              taken_o
);

    always_comb begin
        taken_o = (cond_i == COND_W'(JC_ALWAYS)) ? 1'b1 :
                  (cond_i == COND_W'(JC_NZ))     ? !z_i :
                  (cond_i == COND_W'(JC_Z))      ? z_i  : 1'b0;
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control unit
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   bus        instr_sequencer_if.master: start/instruction/Z_out/mem_ack in,
//              PC_control, IRAM/IR strobes, ALU/regfile/memory strobes, busy/done/fault out
//   MEM_TMO    data-memory wait cycles before the fault trap (0 disables)
module instr_sequencer
    import proc_defs_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int COND_W  = 4,
    parameter int MEM_TMO = 255
) (
    input logic               clock,
    input logic               reset_n,
    instr_sequencer_if.master bus
);

    localparam int TMO_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;

    state_e             state_q, state_d;
    logic [15:8]        ir_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               done_q;
    logic               fault_q;
    logic [OPC_W-1:0]   opc;
    logic [COND_W-1:0]  cond;
    logic               is_nop, is_jmp, is_ld, is_st, is_alu, is_ldi, is_end, illegal;
    logic               taken;
    logic               tmo_hit;

    // Only the opcode and cond/func fields are needed here; the low byte goes to the datapath.
    assign opc     = ir_q[15 -: OPC_W];
    assign cond    = ir_q[11 -: COND_W];
    assign is_nop  = opc == OPC_W'(OP_NOP);
    assign is_jmp  = opc == OPC_W'(OP_JMP);
    assign is_ld   = opc == OPC_W'(OP_LOAD);
    assign is_st   = opc == OPC_W'(OP_STORE);
    assign is_alu  = opc == OPC_W'(OP_ALU);
    assign is_ldi  = opc == OPC_W'(OP_LDI);
    assign is_end  = opc == OPC_W'(OP_END);
    assign illegal = !(is_nop || is_jmp || is_ld || is_st || is_alu || is_ldi || is_end);

    // tmo_q counts MEMREQ cycles already spent; the trap fires on the MEM_TMO-th unacked one.
    assign tmo_hit = (MEM_TMO != 0) && (32'(tmo_q) + 32'd1 == 32'(MEM_TMO));

    jump_cond_eval #(.COND_W(COND_W)) u_jce (
        .cond_i  (cond),
        .z_i     (bus.Z_out),
        .taken_o (taken)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_FWAIT;
            S_FWAIT:  state_d = S_DECODE;
            S_DECODE: state_d = is_nop          ? S_PCINC  :
                                is_jmp          ? S_JUMP   :
                                (is_ld || is_st) ? S_MEMREQ :
                                is_alu          ? S_EXEC   :
                                is_ldi          ? S_WBACK  : S_HALT;
            S_EXEC:   state_d = S_PCINC;
            S_WBACK:  state_d = S_PCINC;
            S_MEMREQ: state_d = bus.mem_ack ? (is_ld ? S_WBACK : S_PCINC) :
                                tmo_hit     ? S_HALT : S_MEMREQ;
            S_JUMP:   state_d = S_FETCH;
            S_PCINC:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FWAIT) ir_q <= bus.instruction[15:8];
            tmo_q   <= (state_q == S_MEMREQ) ? tmo_q + 1'b1 : '0;
            done_q  <= (state_q == S_DECODE) && is_end;
            fault_q <= fault_q || ((state_q == S_DECODE) && illegal) ||
                       ((state_q == S_MEMREQ) && !bus.mem_ack && tmo_hit);
        end
    end

    // Z_out is looked at only while in JUMP, so only taken jumps produce PC_JMP.
    assign bus.PC_control = (state_q == S_PCINC) ? PC_INC :
                            (state_q == S_JUMP)  ? (taken ? PC_JMP : PC_INC) : PC_HOLD;
    assign bus.iram_en    = state_q == S_FETCH;
    assign bus.ir_load    = state_q == S_FWAIT;
    assign bus.alu_en     = state_q == S_EXEC;
    assign bus.alu_op     = is_alu ? 4'(cond) : 4'b0;
    assign bus.reg_we     = state_q == S_WBACK;
    assign bus.imm_sel    = (state_q == S_WBACK) && is_ldi;
    assign bus.mem_req    = state_q == S_MEMREQ;
    assign bus.mem_we     = (state_q == S_MEMREQ) && is_st;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; acts as PC/IRAM/datapath around instr_sequencer
module tb_instr_sequencer;

    typedef struct {
        int k;
        int c;
        int v;
    } ev_t;

    localparam int EV_PC = 1, EV_ALU = 2, EV_WB = 3, EV_MEM = 4, EV_DONE = 5, EV_FLT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] iram [256];
    logic [7:0]  pc;
    logic [15:0] ir_m;
    logic        req_p = 1'b0;
    logic        flt_p = 1'b0;
    logic        we0 = 1'b0;
    ev_t         sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tick = 0;
    int          t0 = 0;
    int          ack_dly = 0;
    int          rcnt = 0;
    int          jc[6] = '{0, 1, 1, 2, 2, 5};
    int          jz[6] = '{0, 0, 1, 1, 0, 1};
    int          jx[6] = '{2, 2, 1, 2, 1, 1};

    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer #(.OPC_W(4), .COND_W(4), .MEM_TMO(4)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.PC_control, bus.iram_en, bus.ir_load, bus.alu_en, bus.alu_op, bus.reg_we,
                bus.imm_sel, bus.mem_req, bus.mem_we, bus.busy, bus.done, bus.fault};
    endfunction

    task automatic exp_ev(input int k, input int c, input int v);
        sb.push_back('{k, c, v});
    endtask

    always @(posedge clk) tick <= tick + 1;

    // PC, IRAM and IR model driven by the sequencer's strobes
    always @(posedge clk) begin
        if (!rst_n) pc <= 8'h00;
        else if (bus.PC_control == 2'b01) pc <= pc + 8'h01;
        else if (bus.PC_control == 2'b10) pc <= ir_m[7:0];
        if (bus.iram_en) bus.instruction <= iram[pc];
        if (bus.ir_load) ir_m <= bus.instruction;
    end

    // data memory: ack in the ack_dly-th cycle of a request, never when ack_dly is 0
    always @(negedge clk) begin
        if (bus.mem_req) begin
            rcnt = rcnt + 1;
            bus.mem_ack = (ack_dly != 0) && (rcnt == ack_dly);
        end else begin
            rcnt = 0;
            bus.mem_ack = 1'b0;
        end
    end

    // at most one strobe event per cycle; each is popped and checked against the scoreboard
    always @(negedge clk) begin : mon
        int  k;
        int  v;
        ev_t e;
        k = 0;
        v = 0;
        if (bus.PC_control != 2'b00) begin k = EV_PC; v = int'(bus.PC_control); end
        else if (bus.alu_en) begin k = EV_ALU; v = int'(bus.alu_op); end
        else if (bus.reg_we) begin k = EV_WB; v = int'(bus.imm_sel); end
        else if (bus.mem_req && !req_p) begin k = EV_MEM; v = int'(bus.mem_we); we0 = bus.mem_we; end
        else if (bus.done) k = EV_DONE;
        else if (bus.fault && !flt_p) k = EV_FLT;
        if (bus.mem_req && req_p) chk("mem_we_hold", bus.mem_we, we0);
        req_p = bus.mem_req;
        flt_p = bus.fault;
        if (k != 0) begin
            if (sb.size() == 0) chk("unexpected_event", k, 0);
            else begin
                e = sb.pop_front();
                chk("ev_kind", k, e.k);
                chk("ev_cycle", tick - t0, e.c);
                chk("ev_val", v, e.v);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_outs", outs(), 16'h0000);
            chk("rst_busy", bus.busy, 0);
        end
        rst_n = 1'b1;
        bus.start = 1'b0;
        sb.delete();
        for (int i = 0; i < 256; i++) iram[i] = 16'hF000;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        t0 = tick;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int i = 0;
        while (i < budget && !(bus.done || bus.fault)) begin
            @(negedge clk);
            i++;
        end
        chk("finished", bus.done | bus.fault, 1);
        @(negedge clk);
        chk("done_is_pulse", bus.done, 0);
        chk("busy_after", bus.busy, 0);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by time limit, expected summary");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.Z_out = 1'b0;
        do_reset();

        // NOP then END
        iram[0] = 16'h0000;
        iram[1] = 16'hF000;
        exp_ev(EV_PC, 4, 1);
        exp_ev(EV_DONE, 8, 0);
        start_pulse();
        wait_end(40);
        chk("nop_pc", pc, 8'h01);

        // conditional jumps to 0x40 over the condition/Z table
        for (int j = 0; j < 6; j++) begin
            do_reset();
            iram[0] = {4'h1, 4'(jc[j]), 8'h40};
            bus.Z_out = jz[j][0];
            exp_ev(EV_PC, 4, jx[j]);
            exp_ev(EV_DONE, 8, 0);
            start_pulse();
            wait_end(40);
            chk("jmp_pc", pc, (jx[j] == 2) ? 8'h40 : 8'h01);
        end
        bus.Z_out = 1'b0;

        // ALU then LDI then END
        do_reset();
        iram[0] = 16'h4700;
        iram[1] = 16'h5055;
        exp_ev(EV_ALU, 4, 7);
        exp_ev(EV_PC, 5, 1);
        exp_ev(EV_WB, 9, 1);
        exp_ev(EV_PC, 10, 1);
        exp_ev(EV_DONE, 14, 0);
        start_pulse();
        wait_end(40);
        chk("alu_ldi_pc", pc, 8'h02);

        // LOAD with ack in the 3rd request cycle
        do_reset();
        ack_dly = 3;
        iram[0] = 16'h2000;
        exp_ev(EV_MEM, 4, 0);
        exp_ev(EV_WB, 7, 0);
        exp_ev(EV_PC, 8, 1);
        exp_ev(EV_DONE, 12, 0);
        start_pulse();
        wait_end(40);

        // STORE acked in the same cycle the request rises
        do_reset();
        ack_dly = 1;
        iram[0] = 16'h3000;
        exp_ev(EV_MEM, 4, 1);
        exp_ev(EV_PC, 5, 1);
        exp_ev(EV_DONE, 9, 0);
        start_pulse();
        wait_end(40);

        // illegal opcode
        do_reset();
        iram[0] = 16'h9000;
        exp_ev(EV_FLT, 4, 0);
        start_pulse();
        wait_end(40);
        chk("illegal_fault", bus.fault, 1);

        // memory timeout, then start is ignored in HALT
        do_reset();
        ack_dly = 0;
        iram[0] = 16'h3000;
        exp_ev(EV_MEM, 4, 1);
        exp_ev(EV_FLT, 8, 0);
        start_pulse();
        wait_end(40);
        start_pulse();
        repeat (6) @(negedge clk);
        chk("halt_ignores_start", outs(), 16'h0001);

        // reset in the middle of a STORE request
        do_reset();
        ack_dly = 0;
        iram[0] = 16'h3000;
        exp_ev(EV_MEM, 4, 1);
        start_pulse();
        repeat (4) @(negedge clk);
        chk("store_req_before_rst", bus.mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_store_outs", outs(), 16'h0000);
        rst_n = 1'b1;
        chk("rst_mid_store_sb", sb.size(), 0);
        repeat (2) @(negedge clk);
        chk("idle_after_rst", outs(), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
